// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller.
// Holds access-size encodings, the controller state enum, the MIPS
// load/store opcodes that map onto this controller, and a small
// alignment helper shared by the top level.
package data_mem_ctrl_pkg;

    // data_size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_ILL  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // MIPS load/store opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_ctrl_lane.sv
// mem_lane_align: purely combinational byte-lane logic.
//   size_i     access size (SZ_*)
//   byte_off_i addr[1:0] of the access
//   sign_i     sign-extend sub-word loads
//   wdata_i    right-aligned store data
//   rword_i    word read from the array
//   be_o       little-endian byte enables for the store
//   wlane_o    store data replicated onto every candidate lane
//   rdata_o    load data shifted to bit 0 and extended
module mem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  byte_off_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{byte_off_i, 3'b000} +: 8];
    assign half_sel = rword_i[{byte_off_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o    = 4'b0000;
        wlane_o = wdata_i;
        rdata_o = '0;
        unique case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << byte_off_i;
                wlane_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o    = byte_off_i[1] ? 4'b1100 : 4'b0011;
                wlane_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_i & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                be_o    = 4'b0000;
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data memory with an IDLE/BUSY/DONE handshake.
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read, mem_write   load / store request (held stable while stall=1)
//   data_size, mem_signed access size and load extension mode
//   addr, wdata           byte address, right-aligned store data
//   rdata                 load result, non-zero only while done=1
//   stall                 freeze request to the pipeline
//   done, err             one-cycle completion and error pulses
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  data_size,
    input  logic        mem_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    // Captured request; only meaningful while BUSY
    logic              is_write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;

    logic              req;
    logic              req_err;
    logic              finish_d;
    logic              commit_d;
    logic [3:0]        be_d;
    logic [31:0]       wlane_d;
    logic [31:0]       ld_data_d;

    assign req     = mem_read | mem_write;
    assign req_err = (mem_read & mem_write) ||
                     (data_size == SZ_ILL) ||
                     is_misaligned(data_size, addr[1:0]) ||
                     ({2'b00, addr[31:2]} >= 32'(DEPTH));

    assign finish_d = (state_q == BUSY) && (cnt_q == 4'd0);
    // Gating with rst_n keeps an aborted store from landing in the array.
    assign commit_d = rst_n && finish_d && is_write_q;

    mem_lane_align u_lane (
        .size_i     (size_q),
        .byte_off_i (off_q),
        .sign_i     (signed_q),
        .wdata_i    (wdata_q),
        .rword_i    (mem[idx_q]),
        .be_o       (be_d),
        .wlane_o    (wlane_d),
        .rdata_o    (ld_data_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    if (req) begin
                        if (req_err) begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        rdata_q <= is_write_q ? 32'd0 : ld_data_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            is_write_q <= mem_write;
            size_q     <= data_size;
            signed_q   <= mem_signed;
            off_q      <= addr[1:0];
            idx_q      <= addr[IDX_W+1:2];
            wdata_q    <= wdata;
        end
    end

    // Array has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (commit_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem[idx_q][8*i +: 8] <= wlane_d[8*i +: 8];
            end
        end
    end

    assign stall = ((state_q == IDLE) && req) || (state_q == BUSY);
    assign done  = (state_q == DONE);
    assign err   = err_q;
    assign rdata = (state_q == DONE) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_signed;
    logic [1:0]  data_size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, done, err;

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .data_size  (data_size),
        .mem_signed (mem_signed),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
        int          lat;
        int          start;
    } expect_t;

    expect_t     exp_q[$];
    logic [7:0]  mem_m [4*DEPTH];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          stall_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: byte-addressed array, sizes as byte counts.
    function automatic void model_access(input logic rd, input logic wr,
                                         input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic e_err, output logic [31:0] e_rd,
                                         output logic e_chk);
        int n;
        int base;
        logic [31:0] v;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e_err = (rd && wr) || (sz == 2'b10) || (a % n != 0) || ((a / 4) >= DEPTH);
        e_rd  = 32'd0;
        e_chk = 1'b1;
        if (e_err) return;
        base = int'(a);
        if (wr) begin
            for (int k = 0; k < n; k++) mem_m[base + k] = wd[8*k +: 8];
            e_chk = 1'b0;
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[base + k];
            if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
            e_rd = v;
        end
    endfunction

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; data_size = 2'b00; mem_signed = 0;
        addr = 0; wdata = 0;
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic use_c, input logic [31:0] cval);
        expect_t e;
        int k;
        model_access(rd, wr, sz, sg, a, wd, e.err, e.rdata, e.chk);
        if (use_c) begin
            e.rdata = cval;
            e.chk   = 1'b1;
        end
        e.lat = e.err ? 1 : LATENCY + 1;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; data_size = sz; mem_signed = sg;
        addr = a; wdata = wd;
        e.start = cyc;
        exp_q.push_back(e);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_on_req addr=%h got=%b want=1", a, stall);
        end
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (k == 20) begin
            bad++;
            $display("FAIL done_timeout addr=%h got=no_done want=done", a);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        idle_inputs();
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        expect_t e;
        if (!rst_n) begin
            stall_run = 0;
        end else begin
            if (stall === 1'b1) stall_run++;
            if (done === 1'b1) begin
                total++;
                if (stall !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_done got=%b want=0", stall);
                end
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done got=done want=none");
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (err !== e.err) begin
                        bad++;
                        $display("FAIL err got=%b want=%b", err, e.err);
                    end
                    if (e.chk) begin
                        total++;
                        if (rdata !== e.rdata) begin
                            bad++;
                            $display("FAIL rdata got=%h want=%h", rdata, e.rdata);
                        end
                    end
                    total++;
                    if (cyc - e.start != e.lat) begin
                        bad++;
                        $display("FAIL latency got=%0d want=%0d", cyc - e.start, e.lat);
                    end
                    total++;
                    if (stall_run != e.lat) begin
                        bad++;
                        $display("FAIL stall_cycles got=%0d want=%0d", stall_run, e.lat);
                    end
                end
                stall_run = 0;
            end else begin
                total++;
                if (rdata !== 32'd0 || err !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_outputs rdata=%h err=%b want 0/0", rdata, err);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        total++;
        if (stall !== 0 || done !== 0 || err !== 0 || rdata !== 0) begin
            bad++;
            $display("FAIL %s stall=%b done=%b err=%b rdata=%h want all 0",
                     tag, stall, done, err, rdata);
        end
    endtask

    initial begin
        int op;
        logic [31:0] a;
        logic [1:0]  sz;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_init");
        rst_n = 1'b1;

        // Known array contents
        for (int w = 0; w < DEPTH; w++)
            do_req(0, 1, 2'b11, 0, 32'(w * 4), 32'd0, 0, 32'd0);

        // Word store / load
        do_req(0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 0, 32'd0);
        do_req(1, 0, 2'b11, 0, 32'h10, 32'd0, 1, 32'hDEADBEEF);
        do_req(0, 1, 2'b11, 0, 32'h10, 32'd0, 0, 32'd0);
        // Byte store and extension
        do_req(0, 1, 2'b00, 0, 32'h11, 32'h80, 0, 32'd0);
        do_req(1, 0, 2'b00, 1, 32'h11, 32'd0, 1, 32'hFFFFFF80);
        do_req(1, 0, 2'b00, 0, 32'h11, 32'd0, 1, 32'h00000080);
        do_req(1, 0, 2'b11, 0, 32'h10, 32'd0, 1, 32'h00008000);
        // Halfword
        do_req(0, 1, 2'b01, 0, 32'h16, 32'h1234, 0, 32'd0);
        do_req(1, 0, 2'b01, 1, 32'h16, 32'd0, 1, 32'h00001234);
        do_req(1, 0, 2'b11, 0, 32'h14, 32'd0, 1, 32'h12340000);
        // Errors, each followed by a load showing the array untouched
        do_req(1, 0, 2'b11, 0, 32'h13, 32'd0, 1, 32'd0);
        do_req(0, 1, 2'b01, 0, 32'h15, 32'hFFFF, 1, 32'd0);
        do_req(1, 0, 2'b11, 0, 32'h14, 32'd0, 1, 32'h12340000);
        do_req(0, 1, 2'b10, 0, 32'h10, 32'hFFFFFFFF, 1, 32'd0);
        do_req(1, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 1, 32'd0);
        do_req(1, 0, 2'b11, 0, 32'h10, 32'd0, 1, 32'h00008000);
        do_req(0, 1, 2'b11, 0, 32'(4 * DEPTH), 32'hFFFFFFFF, 1, 32'd0);
        do_req(1, 0, 2'b11, 0, 32'h0, 32'd0, 1, 32'h0);

        // Reset during BUSY of a store
        do_req(0, 1, 2'b11, 0, 32'h20, 32'hCAFE0001, 0, 32'd0);
        @(posedge clk); #1;
        mem_read = 0; mem_write = 1; data_size = 2'b11; addr = 32'h20; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_busy");
        @(negedge clk);
        check_reset_outputs("reset_held");
        @(posedge clk); #2;
        rst_n = 1'b1;
        do_req(1, 0, 2'b11, 0, 32'h20, 32'd0, 1, 32'hCAFE0001);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, DEPTH + 2) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b11) a[1:0] = 2'b00;
                if (sz == 2'b10) sz = 2'b11;
                if (sz == 2'b11) a[1:0] = 2'b00;
            end
            do_req(op < 5 || op == 9, op >= 5, sz, 1'($urandom_range(0, 1)),
                   a, $urandom, 0, 32'd0);
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
